// File: rtl/dtm_tap.sv
// JTAG TAP controller for the debug transport module.
// Define DTM_TAP_IDCODE_EN to implement the IDCODE data register.
module dtm_tap #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
    input  logic tck_i,
    input  logic trst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic tdi_o,
    output logic capture_o,
    output logic shift_o,
    output logic update_o,
    output logic dmi_select_o,
    output logic dtmcs_select_o,
    output logic dmi_clear_o,
    input  logic dmi_tdo_i,
    input  logic dtmcs_tdo_i
);

    localparam logic [IrLength-1:0] IrDtmcs   = IrLength'('h10);
    localparam logic [IrLength-1:0] IrDmi     = IrLength'('h11);
    localparam logic [IrLength-1:0] IrCapture = IrLength'('b00101);
`ifdef DTM_TAP_IDCODE_EN
    localparam logic [IrLength-1:0] IrIdcode = IrLength'('h01);
    localparam logic [IrLength-1:0] IrReset  = IrIdcode;
`else
    localparam logic [IrLength-1:0] IrReset  = '1;
`endif

    typedef enum logic [3:0] {
        TestLogicReset, RunTestIdle,
        SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr,
        SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
    } state_e;

    state_e state_q, state_d;

    logic [IrLength-1:0] ir_q;
    logic [IrLength-1:0] ir_shift_q;
    logic                bypass_q;
    logic                idcode_select;
    logic                idcode_bit;
    logic                tdo_d;
    logic                tdo_oe_d;

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) state_q <= TestLogicReset;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
            RunTestIdle:    state_d = tms_i ? SelectDrScan : RunTestIdle;
            SelectDrScan:   state_d = tms_i ? SelectIrScan : CaptureDr;
            CaptureDr:      state_d = tms_i ? Exit1Dr : ShiftDr;
            ShiftDr:        state_d = tms_i ? Exit1Dr : ShiftDr;
            Exit1Dr:        state_d = tms_i ? UpdateDr : PauseDr;
            PauseDr:        state_d = tms_i ? Exit2Dr : PauseDr;
            Exit2Dr:        state_d = tms_i ? UpdateDr : ShiftDr;
            UpdateDr:       state_d = tms_i ? SelectDrScan : RunTestIdle;
            SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr:      state_d = tms_i ? Exit1Ir : ShiftIr;
            ShiftIr:        state_d = tms_i ? Exit1Ir : ShiftIr;
            Exit1Ir:        state_d = tms_i ? UpdateIr : PauseIr;
            PauseIr:        state_d = tms_i ? Exit2Ir : PauseIr;
            Exit2Ir:        state_d = tms_i ? UpdateIr : ShiftIr;
            UpdateIr:       state_d = tms_i ? SelectDrScan : RunTestIdle;
            default:        state_d = TestLogicReset;
        endcase
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            ir_q       <= IrReset;
            ir_shift_q <= '0;
        end else begin
            if (state_q == TestLogicReset) ir_q <= IrReset;
            else if (state_q == UpdateIr)  ir_q <= ir_shift_q;
            if (state_q == CaptureIr)
                ir_shift_q <= IrCapture;
            else if (state_q == ShiftIr)
                ir_shift_q <= {tdi_i, ir_shift_q[IrLength-1:1]};
        end
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i)                  bypass_q <= 1'b0;
        else if (state_q == CaptureDr) bypass_q <= 1'b0;
        else if (state_q == ShiftDr)   bypass_q <= tdi_i;
    end

`ifdef DTM_TAP_IDCODE_EN
    logic [31:0] idcode_q;

    assign idcode_select = (ir_q == IrIdcode);
    assign idcode_bit    = idcode_q[0];

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            idcode_q <= IdcodeValue;
        end else if (idcode_select) begin
            if (state_q == CaptureDr)    idcode_q <= IdcodeValue;
            else if (state_q == ShiftDr) idcode_q <= {tdi_i, idcode_q[31:1]};
        end
    end
`else
    logic unused_idcode;

    assign unused_idcode = ^IdcodeValue;
    assign idcode_select = 1'b0;
    assign idcode_bit    = 1'b0;
`endif

    assign dmi_select_o   = (ir_q == IrDmi);
    assign dtmcs_select_o = (ir_q == IrDtmcs);
    assign capture_o      = (state_q == CaptureDr);
    assign shift_o        = (state_q == ShiftDr);
    assign update_o       = (state_q == UpdateDr);
    assign dmi_clear_o    = (state_q == TestLogicReset);
    assign tdi_o          = tdi_i;

    always_comb begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
        if (state_q == ShiftIr) begin
            tdo_d    = ir_shift_q[0];
            tdo_oe_d = 1'b1;
        end else if (state_q == ShiftDr) begin
            tdo_oe_d = 1'b1;
            if (dmi_select_o)        tdo_d = dmi_tdo_i;
            else if (dtmcs_select_o) tdo_d = dtmcs_tdo_i;
            else if (idcode_select)  tdo_d = idcode_bit;
            else                     tdo_d = bypass_q;
        end
    end

    // TDO changes on the falling edge so the probe samples it on the next rise.
    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_o    <= tdo_d;
            tdo_oe_o <= tdo_oe_d;
        end
    end

endmodule

// File: tb/tb_dtm_tap.sv
// Directed testbench for dtm_tap.
// Expected values follow DTM_TAP_IDCODE_EN the same way as the design.
module tb_dtm_tap;

    logic tck = 1'b0;
    logic trst, tms, tdi;
    logic tdo, tdo_oe, tdi_o;
    logic capture, shift, update;
    logic dmi_sel, dtmcs_sel, dmi_clear;
    logic dmi_tdo, dtmcs_tdo;

    int checks = 0;
    int errors = 0;

    always #5 tck = ~tck;

    dtm_tap dut (
        .tck_i          (tck),
        .trst_i         (trst),
        .tms_i          (tms),
        .tdi_i          (tdi),
        .tdo_o          (tdo),
        .tdo_oe_o       (tdo_oe),
        .tdi_o          (tdi_o),
        .capture_o      (capture),
        .shift_o        (shift),
        .update_o       (update),
        .dmi_select_o   (dmi_sel),
        .dtmcs_select_o (dtmcs_sel),
        .dmi_clear_o    (dmi_clear),
        .dmi_tdo_i      (dmi_tdo),
        .dtmcs_tdo_i    (dtmcs_tdo)
    );

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic shift_dr(input logic [63:0] din, input int n,
                            output logic [63:0] dout);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        dout[0] = tdo;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i]);
            if (i < n - 1) dout[i+1] = tdo;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout,
                            output logic pre_sel);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        dout[0] = tdo;
        for (int i = 0; i < 5; i++) begin
            step(i == 4, din[i]);
            if (i < 4) dout[i+1] = tdo;
        end
        step(1'b1, 1'b0);
        pre_sel = dmi_sel;
        step(1'b0, 1'b0);
    endtask

    function automatic logic [31:0] reset_scan(input logic [31:0] d);
`ifdef DTM_TAP_IDCODE_EN
        return 32'h0000_0001;
`else
        return d << 1;
`endif
    endfunction

    task automatic test_reset();
        logic [63:0] out;
        trst = 1'b1;
        tms = 1'b0;
        tdi = 1'b0;
        dmi_tdo = 1'b0;
        dtmcs_tdo = 1'b0;
        repeat (3) @(negedge tck);
        #1;
        checks++;
        if ({dmi_clear, capture, shift, update} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 1000",
                     {dmi_clear, capture, shift, update});
        end
        checks++;
        if ({dmi_sel, dtmcs_sel} !== 2'b00) begin
            errors++;
            $display("FAIL reset_selects: got %b expected 00", {dmi_sel, dtmcs_sel});
        end
        checks++;
        if ({tdo, tdo_oe} !== 2'b00) begin
            errors++;
            $display("FAIL reset_tdo: got %b expected 00", {tdo, tdo_oe});
        end
        trst = 1'b0;
        step(1'b0, 1'b0);
        checks++;
        if (dmi_clear !== 1'b0) begin
            errors++;
            $display("FAIL rti_clear: got %b expected 0", dmi_clear);
        end
        shift_dr(64'hDEAD_BEEF, 32, out);
        checks++;
        if (out[31:0] !== reset_scan(32'hDEAD_BEEF)) begin
            errors++;
            $display("FAIL reset_dr_scan: got %h expected %h",
                     out[31:0], reset_scan(32'hDEAD_BEEF));
        end
    endtask

    task automatic test_ir_scan();
        logic [4:0] cap;
        logic pre;
        shift_ir(5'h11, cap, pre);
        checks++;
        if (cap !== 5'b00101) begin
            errors++;
            $display("FAIL ir_capture: got %b expected 00101", cap);
        end
        checks++;
        if (pre !== 1'b0) begin
            errors++;
            $display("FAIL sel_in_update_ir: got %b expected 0", pre);
        end
        checks++;
        if ({dmi_sel, dtmcs_sel} !== 2'b10) begin
            errors++;
            $display("FAIL dmi_select: got %b expected 10", {dmi_sel, dtmcs_sel});
        end
    endtask

    task automatic test_dtmcs_scan();
        logic [4:0] cap;
        logic pre;
        logic [10:0] tms_seq;
        logic [5:0] pat;
        int cap_n, sh_n, up_n;
        logic sel_ok;
        tms_seq = 11'b011_0000_0001;
        pat = 6'b101100;
        cap_n = 0;
        sh_n = 0;
        up_n = 0;
        sel_ok = 1'b1;
        shift_ir(5'h10, cap, pre);
        checks++;
        if ({dmi_sel, dtmcs_sel} !== 2'b01) begin
            errors++;
            $display("FAIL dtmcs_select: got %b expected 01", {dmi_sel, dtmcs_sel});
        end
        for (int k = 0; k < 11; k++) begin
            dtmcs_tdo = (k >= 2 && k <= 7) ? pat[k-2] : 1'b0;
            step(tms_seq[k], 1'b0);
            cap_n += int'(capture);
            sh_n += int'(shift);
            up_n += int'(update);
            if (dtmcs_sel !== 1'b1) sel_ok = 1'b0;
            if (k >= 2 && k <= 7) begin
                checks++;
                if (tdo !== pat[k-2]) begin
                    errors++;
                    $display("FAIL dtmcs_tdo bit %0d: got %b expected %b",
                             k - 2, tdo, pat[k-2]);
                end
            end
        end
        dtmcs_tdo = 1'b0;
        checks++;
        if (cap_n != 1 || sh_n != 6 || up_n != 1) begin
            errors++;
            $display("FAIL strobe_counts: got %0d/%0d/%0d expected 1/6/1",
                     cap_n, sh_n, up_n);
        end
        checks++;
        if (sel_ok !== 1'b1) begin
            errors++;
            $display("FAIL select_stable: got %b expected 1", sel_ok);
        end
    endtask

    task automatic test_bypass();
        logic [4:0] codes [4];
        logic [4:0] cap;
        logic pre;
        logic [63:0] out;
        int n;
        codes[0] = 5'h05;
        codes[1] = 5'h00;
        codes[2] = 5'h1F;
        codes[3] = 5'h01;
`ifdef DTM_TAP_IDCODE_EN
        n = 3;
`else
        n = 4;
`endif
        for (int c = 0; c < n; c++) begin
            shift_ir(codes[c], cap, pre);
            shift_dr(64'hA5, 8, out);
            checks++;
            if (out[7:0] !== 8'h4A) begin
                errors++;
                $display("FAIL bypass ir=%h: got %h expected 4a", codes[c], out[7:0]);
            end
        end
    endtask

    task automatic test_tlr();
        logic [4:0] cap;
        logic pre;
        shift_ir(5'h11, cap, pre);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        checks++;
        if (dmi_clear !== 1'b0) begin
            errors++;
            $display("FAIL tlr_after_4: got %b expected 0", dmi_clear);
        end
        step(1'b1, 1'b0);
        checks++;
        if (dmi_clear !== 1'b1) begin
            errors++;
            $display("FAIL tlr_from_shiftdr: got %b expected 1", dmi_clear);
        end
        step(1'b0, 1'b0);
        checks++;
        if (dmi_sel !== 1'b0) begin
            errors++;
            $display("FAIL tlr_ir_reset: got %b expected 0", dmi_sel);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (tdo_oe !== 1'b0) begin
            errors++;
            $display("FAIL pause_ir_oe: got %b expected 0", tdo_oe);
        end
        repeat (5) step(1'b1, 1'b0);
        checks++;
        if (dmi_clear !== 1'b1) begin
            errors++;
            $display("FAIL tlr_from_pauseir: got %b expected 1", dmi_clear);
        end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (update !== 1'b1) begin
            errors++;
            $display("FAIL update_dr: got %b expected 1", update);
        end
        repeat (5) step(1'b1, 1'b0);
        checks++;
        if (dmi_clear !== 1'b1) begin
            errors++;
            $display("FAIL tlr_from_updatedr: got %b expected 1", dmi_clear);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_trst_mid_scan();
        logic [4:0] cap;
        logic pre;
        logic [63:0] out;
        shift_ir(5'h11, cap, pre);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (tdo_oe !== 1'b1) begin
            errors++;
            $display("FAIL shift_ir_oe: got %b expected 1", tdo_oe);
        end
        repeat (3) step(1'b0, 1'b1);
        #1;
        trst = 1'b1;
        #1;
        checks++;
        if ({tdo_oe, dmi_sel, dmi_clear} !== 3'b001) begin
            errors++;
            $display("FAIL trst_immediate: got %b expected 001",
                     {tdo_oe, dmi_sel, dmi_clear});
        end
        @(negedge tck);
        #1;
        trst = 1'b0;
        step(1'b0, 1'b0);
        shift_dr(64'h1234_5678, 32, out);
        checks++;
        if (out[31:0] !== reset_scan(32'h1234_5678)) begin
            errors++;
            $display("FAIL trst_ir_value: got %h expected %h",
                     out[31:0], reset_scan(32'h1234_5678));
        end
    endtask

    initial begin
        test_reset();
        test_ir_scan();
        test_dtmcs_scan();
        test_bypass();
        test_tlr();
        test_trst_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
